// File: rtl/spike_sched_pkg.sv
// Shared types and constants for the spike-count scheduler: FSM state encoding,
// default channel/count sizing and the channel-index width helper.
package spike_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_NEXT  = 2'd3
  } sched_state_t;

  localparam int DEF_NCH   = 4;
  localparam int DEF_CNT_W = 32;

  // A single channel still needs a one-bit index port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_edge_counter.sv
// One spike channel: rising-edge detect on the raw level and a saturating
// edge counter that restarts on i_clear (an edge in the clear cycle counts as 1).
module spike_edge_counter
  import spike_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_spike,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count
);

  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_edge;
  logic             w_full;

  assign w_edge  = i_spike & ~r_prev;
  assign w_full  = &r_cnt;
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_prev <= i_spike;
      if (i_clear) begin
        r_cnt <= {{(CNT_W-1){1'b0}}, w_edge};
      end else if (w_edge && !w_full) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/spike_cnt_scheduler.sv
// Per-window spike counts scaled by a shared gain and issued one channel at a
// time to a shared muscle unit. Define SPKSCHED_SATURATE_EN to clamp products.
module spike_cnt_scheduler
  import spike_sched_pkg::*;
#(
  parameter  int NCH   = DEF_NCH,
  parameter  int CNT_W = DEF_CNT_W,
  localparam int CH_W  = ch_idx_w(NCH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     spike,
  input  logic               tick,
  input  logic [CNT_W-1:0]   gain,
  input  logic               gain_load,
  input  logic               m_ready,
  output logic               m_valid,
  output logic [CNT_W-1:0]   m_data,
  output logic [CH_W-1:0]    m_chan,
  output logic               clear_out,
  output logic               busy,
  output logic               overrun,
  output sched_state_t       dbg_state
);

  // Handshake: a word moves in any cycle where m_valid && m_ready; once m_valid
  // rises, it and m_data/m_chan hold unchanged until that cycle.

  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NCH - 1);

  sched_state_t     r_state;
  sched_state_t     w_next_state;
  logic [CH_W-1:0]  r_idx;
  logic [CNT_W-1:0] r_gain;
  logic [CNT_W-1:0] r_m_data;
  logic [CH_W-1:0]  r_m_chan;
  logic             r_overrun;
  logic [CNT_W-1:0] r_snap [NCH];
  logic [CNT_W-1:0] w_cnt  [NCH];
  logic [CNT_W-1:0] w_snap_sel;
  logic [CNT_W-1:0] w_prod_out;
  logic             w_take;
  logic             w_last;

  assign w_take = tick && (r_state == ST_IDLE) && !reset;
  assign w_last = (r_idx == LAST_IDX);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    spike_edge_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_spike (spike[gi]),
      .i_clear (w_take),
      .o_count (w_cnt[gi])
    );
  end

  assign w_snap_sel = r_snap[r_idx];

`ifdef SPKSCHED_SATURATE_EN
  logic [2*CNT_W-1:0] w_prod;
  assign w_prod     = {{CNT_W{1'b0}}, w_snap_sel} * {{CNT_W{1'b0}}, r_gain};
  assign w_prod_out = (|w_prod[2*CNT_W-1:CNT_W]) ? '1 : w_prod[CNT_W-1:0];
`else
  assign w_prod_out = CNT_W'({{CNT_W{1'b0}}, w_snap_sel} * {{CNT_W{1'b0}}, r_gain});
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    m_valid      = 1'b0;
    busy         = 1'b1;
    clear_out    = w_take;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (tick) w_next_state = ST_LOAD;
      end
      ST_LOAD:  w_next_state = ST_ISSUE;
      ST_ISSUE: begin
        m_valid = 1'b1;
        if (m_ready) w_next_state = ST_NEXT;
      end
      ST_NEXT:  w_next_state = w_last ? ST_IDLE : ST_LOAD;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Product is registered in LOAD, so a later gain_load cannot disturb a word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_gain    <= '0;
      r_m_data  <= '0;
      r_m_chan  <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < NCH; i++) r_snap[i] <= '0;
    end else begin
      if (gain_load) r_gain <= gain;
      if (tick && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      if (w_take) begin
        r_idx <= '0;
        for (int i = 0; i < NCH; i++) r_snap[i] <= w_cnt[i];
      end
      if (r_state == ST_LOAD) begin
        r_m_data <= w_prod_out;
        r_m_chan <= r_idx;
      end
      if ((r_state == ST_NEXT) && !w_last) r_idx <= r_idx + CH_W'(1);
    end
  end

  assign m_data    = r_m_data;
  assign m_chan    = r_m_chan;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spike_cnt_scheduler.sv
// Bench for spike_cnt_scheduler: table-driven windows, hand sequences for
// backpressure/overrun/edge-on-tick/reset, then random traffic against a window model.
module tb_spike_cnt_scheduler;
  import spike_sched_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int W   = 2 + CW;

`ifdef SPKSCHED_SATURATE_EN
  localparam logic [CW-1:0] OVF_A = 32'hFFFF_FFFF;
  localparam logic [CW-1:0] OVF_B = 32'hFFFF_FFFF;
`else
  localparam logic [CW-1:0] OVF_A = 32'hFFFF_FFFE;
  localparam logic [CW-1:0] OVF_B = 32'h0000_0000;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] spike;
  logic           tick;
  logic [CW-1:0]  gain;
  logic           gain_load;
  logic           m_ready;
  logic           m_valid;
  logic [CW-1:0]  m_data;
  logic [1:0]     m_chan;
  logic           clear_out;
  logic           busy;
  logic           overrun;
  sched_state_t   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  spike_cnt_scheduler #(.NCH(NCH), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .spike     (spike),
    .tick      (tick),
    .gain      (gain),
    .gain_load (gain_load),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_chan    (m_chan),
    .clear_out (clear_out),
    .busy      (busy),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [NCH-1:0][7:0] ev(input int a0, input int a1, input int a2, input int a3);
    logic [NCH-1:0][7:0] r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
    return r;
  endfunction

  function automatic logic [NCH-1:0][CW-1:0] dv(input logic [CW-1:0] a0, input logic [CW-1:0] a1,
                                                input logic [CW-1:0] a2, input logic [CW-1:0] a3);
    logic [NCH-1:0][CW-1:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    return r;
  endfunction

  task automatic load_gain(input logic [CW-1:0] g);
    cyc(); gain = g; gain_load = 1'b1;
    cyc(); gain_load = 1'b0;
  endtask

  task automatic drive_edges(input logic [NCH-1:0][7:0] e);
    int mx = 0;
    for (int c = 0; c < NCH; c++) if (int'(e[c]) > mx) mx = int'(e[c]);
    for (int r = 0; r < mx; r++) begin
      cyc();
      for (int c = 0; c < NCH; c++) spike[c] = (r < int'(e[c]));
      cyc();
      spike = '0;
    end
  endtask

  // Ends settled in the first m_valid cycle (or after the bound expires).
  task automatic fire_tick(input string tag);
    int lat = -1;
    cyc(); tick = 1'b1;
    #1 chk({tag, " clear_out"}, clear_out, 1);
    cyc(); tick = 1'b0;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      #1;
      if (m_valid) lat = i;
      else if (i < 8) cyc();
    end
    chk({tag, " latency"}, lat, 2);
  endtask

  // Starts in a settled cycle; ends settled in the cycle of the last handshake.
  task automatic drain(input int n, output logic [NCH-1:0][CW-1:0] d,
                       output logic [NCH-1:0][1:0] ch, output int got);
    got = 0; d = '0; ch = '0;
    for (int i = 0; i < 80 && got < n; i++) begin
      if (i > 0) begin cyc(); #1; end
      if (m_valid && m_ready) begin
        d[got] = m_data; ch[got] = m_chan; got++;
      end
    end
  endtask

  task automatic run_window(input logic [NCH-1:0][7:0] e, input logic [CW-1:0] g,
                            input logic [NCH-1:0][CW-1:0] exp, input string tag);
    logic [NCH-1:0][CW-1:0] d;
    logic [NCH-1:0][1:0]    ch;
    int got;
    m_ready = 1'b1;
    load_gain(g);
    drive_edges(e);
    fire_tick(tag);
    drain(NCH, d, ch, got);
    chk({tag, " words"}, got, NCH);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("%s chan[%0d]", tag, c), ch[c], c);
      chk($sformatf("%s data[%0d]", tag, c), d[c], exp[c]);
    end
    cyc(); #1 chk({tag, " busy in NEXT"}, busy, 1);
    cyc(); #1 chk({tag, " busy after"}, busy, 0);
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0]   exp_q[$];
  logic [CW-1:0]  acc [NCH];
  logic [CW-1:0]  g_model;
  logic [NCH-1:0] prev_spike;
  bit             m_busy;
  int             tail;
  bit             hold_pending;
  logic [W-1:0]   hold_w;
  bit             model_ovr;

  function automatic logic [CW-1:0] scale(input logic [CW-1:0] c, input logic [CW-1:0] g);
    logic [63:0] p;
    p = 64'(c) * 64'(g);
`ifdef SPKSCHED_SATURATE_EN
    return (p > 64'h0000_0000_FFFF_FFFF) ? '1 : p[CW-1:0];
`else
    return p[CW-1:0];
`endif
  endfunction

  task automatic rand_cycle(input bit stim);
    logic [NCH-1:0] edges;
    bit accept;
    cyc();
    gain_load = 1'b0;
    if (stim) begin
      spike   = NCH'($urandom_range(0, 15));
      m_ready = ($urandom_range(0, 3) != 0);
      tick    = ($urandom_range(0, 9) == 0);
      if (!m_busy && !tick && $urandom_range(0, 3) == 0) begin
        gain = ($urandom_range(0, 1) == 1) ? CW'($urandom_range(0, 20)) : CW'($urandom);
        gain_load = 1'b1;
      end
    end else begin
      spike = '0; m_ready = 1'b1; tick = 1'b0;
    end
    #1;
    edges  = spike & ~prev_spike;
    accept = tick && !m_busy;
    chk("rand busy", busy, m_busy);
    chk("rand clear_out", clear_out, accept);
    if (hold_pending) chk("rand hold", {m_valid, m_chan, m_data}, {1'b1, hold_w});
    if (tail > 0) begin
      tail--;
      if (tail == 0) m_busy = 0;
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rand unexpected word: got chan %0d data 0x%0h, required none", m_chan, m_data);
      end else begin
        chk("rand word", {m_chan, m_data}, exp_q.pop_front());
        if (exp_q.size() == 0) tail = 1;
      end
    end
    hold_pending = m_valid && !m_ready;
    hold_w       = {m_chan, m_data};
    if (tick && m_busy && !accept) model_ovr = 1;
    if (accept) begin
      for (int c = 0; c < NCH; c++) begin
        exp_q.push_back({2'(c), scale(acc[c], g_model)});
        acc[c] = CW'(edges[c]);
      end
      m_busy = 1;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (edges[c] && acc[c] != '1) acc[c] = acc[c] + 1;
    end
    if (gain_load) g_model = gain;
    prev_spike = spike;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NCH-1:0][7:0]    e;
    logic [CW-1:0]          g;
    logic [NCH-1:0][CW-1:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [NCH-1:0][CW-1:0] d;
    logic [NCH-1:0][1:0]    ch;
    logic [CW-1:0]          hold_d;
    logic [1:0]             hold_c;
    int  got;
    bit  stable, saw;

    tbl[0] = '{ev(5, 0, 2, 0), 32'd3,          dv(32'd15, 32'd0, 32'd6, 32'd0)};
    tbl[1] = '{ev(1, 2, 3, 4), 32'd0,          dv(32'd0, 32'd0, 32'd0, 32'd0)};
    tbl[2] = '{ev(1, 0, 0, 2), 32'hFFFF_FFFF,  dv(32'hFFFF_FFFF, 32'd0, 32'd0, OVF_A)};
    tbl[3] = '{ev(2, 0, 0, 0), 32'h8000_0000,  dv(OVF_B, 32'd0, 32'd0, 32'd0)};
    tbl[4] = '{ev(0, 7, 0, 1), 32'd1,          dv(32'd0, 32'd7, 32'd0, 32'd1)};
    tbl[5] = '{ev(0, 0, 1, 0), 32'h0001_0000,  dv(32'd0, 32'd0, 32'h0001_0000, 32'd0)};

    // reset
    reset = 1'b1; spike = '0; tick = 1'b0; gain = '0; gain_load = 1'b0; m_ready = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    chk("reset m_valid", m_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset overrun", overrun, 0);
    chk("reset clear_out", clear_out, 0);
    chk("reset m_data", m_data, 0);
    chk("reset m_chan", m_chan, 0);
    chk("reset state", dbg_state, ST_IDLE);

    // table windows
    for (int v = 0; v < 6; v++) run_window(tbl[v].e, tbl[v].g, tbl[v].exp, $sformatf("vec%0d", v));

    // backpressure: ten stalled cycles, then exactly one handshake
    m_ready = 1'b0;
    load_gain(32'd2);
    drive_edges(ev(0, 3, 0, 0));
    fire_tick("bp");
    hold_d = m_data; hold_c = m_chan; stable = 1;
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      if (!m_valid || m_data !== hold_d || m_chan !== hold_c) stable = 0;
    end
    chk("bp held stable", stable, 1);
    chk("bp chan0", hold_c, 0);
    chk("bp data0", hold_d, 0);
    cyc(); m_ready = 1'b1; #1 chk("bp release valid", m_valid, 1);
    cyc(); m_ready = 1'b0; #1 chk("bp one handshake", m_valid, 0);
    m_ready = 1'b1;
    drain(3, d, ch, got);
    chk("bp rest words", got, 3);
    chk("bp next chan", ch[0], 1);
    chk("bp next data", d[0], 6);
    chk("bp overrun clean", overrun, 0);
    cyc(); cyc();

    // tick while busy
    m_ready = 1'b0;
    load_gain(32'd1);
    drive_edges(ev(1, 0, 0, 0));
    fire_tick("ovr");
    cyc(); tick = 1'b1; #1 chk("ovr no clear_out", clear_out, 0);
    cyc(); tick = 1'b0; #1 chk("ovr set", overrun, 1);
    drive_edges(ev(0, 0, 2, 0));
    #1 m_ready = 1'b1;
    drain(NCH, d, ch, got);
    chk("ovr words", got, NCH);
    chk("ovr ch0", d[0], 1);
    chk("ovr ch2 old window", d[2], 0);
    cyc(); cyc();
    drive_edges(ev(0, 0, 1, 0));
    fire_tick("ovr2");
    drain(NCH, d, ch, got);
    chk("ovr2 ch2 combined", d[2], 3);
    chk("ovr2 ch0", d[0], 0);
    chk("ovr sticky", overrun, 1);
    cyc(); cyc();

    // edge in the tick cycle belongs to the new window
    drive_edges(ev(0, 0, 0, 2));
    cyc(); tick = 1'b1; spike[3] = 1'b1;
    #1 chk("eot clear_out", clear_out, 1);
    cyc(); tick = 1'b0; #1;
    drain(NCH, d, ch, got);
    chk("eot old window", d[3], 2);
    cyc(); cyc(); spike = '0;
    fire_tick("eot2");
    drain(NCH, d, ch, got);
    chk("eot new window", d[3], 1);
    cyc(); cyc();

    // reset in the middle of ISSUE discards the window
    m_ready = 1'b0;
    drive_edges(ev(0, 0, 0, 1));
    fire_tick("rst");
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    #1;
    chk("rst m_valid", m_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst overrun", overrun, 0);
    chk("rst m_data", m_data, 0);
    m_ready = 1'b1; saw = 0;
    for (int i = 0; i < 6; i++) begin cyc(); #1; if (m_valid) saw = 1; end
    chk("rst discarded", saw, 0);

    // random traffic against the window model (gain was reset to 0)
    g_model = '0; prev_spike = spike; m_busy = 0; tail = 0;
    hold_pending = 0; model_ovr = 0;
    for (int c = 0; c < NCH; c++) acc[c] = '0;
    for (int t = 0; t < 1500; t++) rand_cycle(1);
    for (int t = 0; t < 120 && (m_busy || exp_q.size() != 0); t++) rand_cycle(0);
    chk("rand drained", exp_q.size(), 0);
    chk("rand overrun", overrun, model_ovr);
    cyc(); #1 chk("rand idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
